// File: rtl/riscv_fetch_ctrl_pkg.sv
// Shared types for the variable-latency fetch controller: XLEN and the FSM state encoding.
package riscv_fetch_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_KILL = 2'd2
    } fetch_state_e;

    // Memory access in flight, whether or not its data is still wanted.
    function automatic logic fetch_busy(input fetch_state_e s);
        return (s == ST_WAIT) || (s == ST_KILL);
    endfunction

endpackage

// File: rtl/riscv_fetch_buf.sv
// One-entry instruction/PC holding buffer; clear wins over write, read empties the entry.
module riscv_fetch_buf
    import riscv_fetch_ctrl_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_wr,
    input  logic            i_rd,
    input  logic            i_clr,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (i_clr || i_rd) begin
            valid_d = 1'b0;
        end else if (i_wr) begin
            valid_d = 1'b1;
            instr_d = i_instr;
            pc_d    = i_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign o_valid = valid_q;
    assign o_instr = instr_q;
    assign o_pc    = pc_q;

endmodule

// File: rtl/riscv_fetch_ctrl.sv
// Fetch sequencing for a grant/response instruction memory, one access outstanding.
// Optional performance counters are built when RISCV_FETCH_CTRL_PERF_EN is defined.
module riscv_fetch_ctrl
    import riscv_fetch_ctrl_pkg::*;
#(
    parameter int PERF_CNT_W = 32
)
(
    input  logic                  i_clk,
    input  logic                  i_rstn,
    output logic                  o_imem_req,
    output logic [XLEN-1:0]       o_imem_addr,
    input  logic                  i_imem_gnt,
    input  logic                  i_imem_rvalid,
    input  logic [XLEN-1:0]       i_imem_rdata,
    input  logic [XLEN-1:0]       i_pc_f,
    input  logic                  i_pc_src_e,
    input  logic                  i_stall_d,
    output logic                  o_pc_en,
    output logic                  o_ifid_en,
    output logic                  o_flush_d,
    output logic [XLEN-1:0]       o_instr_f,
    output logic [XLEN-1:0]       o_pc_instr_f,
    output logic [PERF_CNT_W-1:0] o_perf_wait_cnt,
    output logic [PERF_CNT_W-1:0] o_perf_kill_cnt,
    output logic [1:0]            o_dbg_state
);

    // Handshake: a request is accepted in the cycle where o_imem_req and i_imem_gnt
    // are both high; the response arrives as a one-cycle i_imem_rvalid pulse at
    // least one cycle later, with no backpressure on the response side.

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] r_addr_q, r_addr_d;

    logic            buf_valid;
    logic [XLEN-1:0] buf_instr;
    logic [XLEN-1:0] buf_pc;

    logic req;
    logic deliver_mem;
    logic deliver_buf;
    logic deliver;
    logic buf_wr;
    logic kill_evt;

    always_comb begin
        state_d     = state_q;
        r_addr_d    = r_addr_q;
        req         = 1'b0;
        deliver_mem = 1'b0;
        buf_wr      = 1'b0;
        kill_evt    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req = ~buf_valid & ~i_pc_src_e;
                if (req && i_imem_gnt) begin
                    r_addr_d = i_pc_f;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_imem_rvalid) begin
                    state_d = ST_IDLE;
                    if (i_pc_src_e) begin
                        kill_evt = 1'b1;
                    end else if (i_stall_d) begin
                        buf_wr = 1'b1;
                    end else begin
                        deliver_mem = 1'b1;
                    end
                end else if (i_pc_src_e) begin
                    state_d  = ST_KILL;
                    kill_evt = 1'b1;
                end
            end
            ST_KILL: begin
                if (i_imem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The buffer is only ever filled from WAIT, and no request issues while it is
    // full, so a buffer drain and a memory return never coincide.
    assign deliver_buf = buf_valid & ~i_stall_d & ~i_pc_src_e;
    assign deliver     = deliver_mem | deliver_buf;

    riscv_fetch_buf u_buf (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_wr    (buf_wr),
        .i_rd    (deliver_buf),
        .i_clr   (i_pc_src_e),
        .i_instr (i_imem_rdata),
        .i_pc    (r_addr_q),
        .o_valid (buf_valid),
        .o_instr (buf_instr),
        .o_pc    (buf_pc)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            r_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            r_addr_q <= r_addr_d;
        end
    end

    // Every output is forced low while reset is asserted, independent of inputs.
    always_comb begin
        o_imem_req   = i_rstn & req;
        o_imem_addr  = i_rstn ? i_pc_f : '0;
        o_pc_en      = i_rstn & (deliver | i_pc_src_e);
        o_ifid_en    = i_rstn & ~i_stall_d;
        o_flush_d    = i_rstn & (i_pc_src_e | (~i_stall_d & ~deliver));
        o_instr_f    = '0;
        o_pc_instr_f = '0;
        if (i_rstn && deliver_mem) begin
            o_instr_f    = i_imem_rdata;
            o_pc_instr_f = r_addr_q;
        end else if (i_rstn && deliver_buf) begin
            o_instr_f    = buf_instr;
            o_pc_instr_f = buf_pc;
        end
    end

    assign o_dbg_state = state_q;

`ifdef RISCV_FETCH_CTRL_PERF_EN
    logic [PERF_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [PERF_CNT_W-1:0] kill_cnt_q, kill_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        kill_cnt_d = kill_cnt_q;
        if (fetch_busy(state_q) && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + PERF_CNT_W'(1);
        end
        if (kill_evt && (kill_cnt_q != '1)) begin
            kill_cnt_d = kill_cnt_q + PERF_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wait_cnt_q <= '0;
            kill_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            kill_cnt_q <= kill_cnt_d;
        end
    end

    assign o_perf_wait_cnt = i_rstn ? wait_cnt_q : '0;
    assign o_perf_kill_cnt = i_rstn ? kill_cnt_q : '0;
`else
    logic unused_kill_evt;
    assign unused_kill_evt = kill_evt;
    assign o_perf_wait_cnt = '0;
    assign o_perf_kill_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// Self-checking bench for riscv_fetch_ctrl: directed scenarios plus a randomized
// run against a program-order PC/instruction reference stream.
module tb_riscv_fetch_ctrl;
    import riscv_fetch_ctrl_pkg::*;

    localparam int PW = 32;

    logic            i_clk = 1'b0;
    logic            i_rstn;
    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_gnt;
    logic            i_imem_rvalid;
    logic [XLEN-1:0] i_imem_rdata;
    logic [XLEN-1:0] i_pc_f;
    logic            i_pc_src_e;
    logic            i_stall_d;
    logic            o_pc_en;
    logic            o_ifid_en;
    logic            o_flush_d;
    logic [XLEN-1:0] o_instr_f;
    logic [XLEN-1:0] o_pc_instr_f;
    logic [PW-1:0]   o_perf_wait_cnt;
    logic [PW-1:0]   o_perf_kill_cnt;
    logic [1:0]      o_dbg_state;

    int compared   = 0;
    int mismatched = 0;

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] exp_q[$];

    riscv_fetch_ctrl #(.PERF_CNT_W(PW)) dut (
        .i_clk           (i_clk),
        .i_rstn          (i_rstn),
        .o_imem_req      (o_imem_req),
        .o_imem_addr     (o_imem_addr),
        .i_imem_gnt      (i_imem_gnt),
        .i_imem_rvalid   (i_imem_rvalid),
        .i_imem_rdata    (i_imem_rdata),
        .i_pc_f          (i_pc_f),
        .i_pc_src_e      (i_pc_src_e),
        .i_stall_d       (i_stall_d),
        .o_pc_en         (o_pc_en),
        .o_ifid_en       (o_ifid_en),
        .o_flush_d       (o_flush_d),
        .o_instr_f       (o_instr_f),
        .o_pc_instr_f    (o_pc_instr_f),
        .o_perf_wait_cnt (o_perf_wait_cnt),
        .o_perf_kill_cnt (o_perf_kill_cnt),
        .o_dbg_state     (o_dbg_state)
    );

    // ---------------- clock / reset / PC register ----------------
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)      pc_reg <= '0;
        else if (o_pc_en) pc_reg <= i_pc_src_e ? target : pc_reg + 32'd4;
    end
    assign i_pc_f = pc_reg;

    // Protocol monitors: grant without request, response with nothing outstanding.
    always @(negedge i_clk) begin
        if (i_rstn) begin
            compared++;
            if (i_imem_gnt && !o_imem_req) begin
                mismatched++;
                $display("FAIL proto_gnt_without_req: gnt=%0b req=%0b", i_imem_gnt, o_imem_req);
            end
            compared++;
            if (i_imem_rvalid && o_dbg_state == 2'd0) begin
                mismatched++;
                $display("FAIL proto_rvalid_in_idle: rvalid=%0b state=%0d", i_imem_rvalid, o_dbg_state);
            end
        end
    end

    function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_quiet();
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = '0;
        i_pc_src_e    = 1'b0;
        i_stall_d     = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_reset();
        i_rstn = 1'b0;
        drive_quiet();
        target = '0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        i_rstn        = 1'b0;
        i_imem_gnt    = 1'b1;
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = 32'hFFFF_FFFF;
        i_pc_src_e    = 1'b1;
        i_stall_d     = 1'b0;
        target        = 32'h0000_0100;
        #1;
        compared++; if (o_imem_req !== 1'b0) begin mismatched++; $display("FAIL rst_req: got %0b want 0", o_imem_req); end
        compared++; if (o_imem_addr !== '0) begin mismatched++; $display("FAIL rst_addr: got %0h want 0", o_imem_addr); end
        compared++; if (o_pc_en !== 1'b0) begin mismatched++; $display("FAIL rst_pc_en: got %0b want 0", o_pc_en); end
        compared++; if (o_ifid_en !== 1'b0) begin mismatched++; $display("FAIL rst_ifid_en: got %0b want 0", o_ifid_en); end
        compared++; if (o_flush_d !== 1'b0) begin mismatched++; $display("FAIL rst_flush: got %0b want 0", o_flush_d); end
        compared++; if (o_instr_f !== '0) begin mismatched++; $display("FAIL rst_instr: got %0h want 0", o_instr_f); end
        compared++; if (o_pc_instr_f !== '0) begin mismatched++; $display("FAIL rst_pc_instr: got %0h want 0", o_pc_instr_f); end
        compared++; if (o_perf_wait_cnt !== '0 || o_perf_kill_cnt !== '0) begin mismatched++; $display("FAIL rst_perf: got %0d/%0d want 0/0", o_perf_wait_cnt, o_perf_kill_cnt); end
        apply_reset();
    endtask

    task automatic test_single_cycle();
        logic [PW-1:0] exp_wait;
        apply_reset();
        i_imem_gnt = 1'b1;
        #1;
        compared++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin mismatched++; $display("FAIL sc_first_req: got req=%0b addr=%0h want 1/0", o_imem_req, o_imem_addr); end
        next_cycle();
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = 32'h0000_0013;
        #1;
        compared++; if (o_instr_f !== 32'h13 || o_pc_instr_f !== 32'h0) begin mismatched++; $display("FAIL sc_deliver: got %0h@%0h want 13@0", o_instr_f, o_pc_instr_f); end
        compared++; if (o_pc_en !== 1'b1 || o_flush_d !== 1'b0 || o_ifid_en !== 1'b1) begin mismatched++; $display("FAIL sc_ctrl: got pc_en=%0b flush=%0b ifid=%0b want 1/0/1", o_pc_en, o_flush_d, o_ifid_en); end
        next_cycle();
        drive_quiet();
        #1;
        compared++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h4) begin mismatched++; $display("FAIL sc_next_req: got req=%0b addr=%0h want 1/4", o_imem_req, o_imem_addr); end
`ifdef RISCV_FETCH_CTRL_PERF_EN
        exp_wait = 1;
`else
        exp_wait = 0;
`endif
        compared++; if (o_perf_wait_cnt !== exp_wait) begin mismatched++; $display("FAIL sc_wait_cnt: got %0d want %0d", o_perf_wait_cnt, exp_wait); end
    endtask

    task automatic test_slow_mem();
        logic [PW-1:0] exp_wait;
        apply_reset();
        i_imem_gnt = 1'b1;
        next_cycle();
        i_imem_gnt = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            #1;
            compared++; if (o_flush_d !== 1'b1 || o_pc_en !== 1'b0 || o_imem_req !== 1'b0) begin mismatched++; $display("FAIL slow_wait_T+%0d: got flush=%0b pc_en=%0b req=%0b want 1/0/0", k, o_flush_d, o_pc_en, o_imem_req); end
            next_cycle();
        end
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = 32'h00A0_0093;
        #1;
        compared++; if (o_instr_f !== 32'h00A0_0093 || o_pc_instr_f !== 32'h0 || o_pc_en !== 1'b1) begin mismatched++; $display("FAIL slow_deliver: got %0h@%0h pc_en=%0b want a00093@0 1", o_instr_f, o_pc_instr_f, o_pc_en); end
        next_cycle();
        drive_quiet();
        #1;
`ifdef RISCV_FETCH_CTRL_PERF_EN
        exp_wait = 3;
`else
        exp_wait = 0;
`endif
        compared++; if (o_perf_wait_cnt !== exp_wait) begin mismatched++; $display("FAIL slow_wait_cnt: got %0d want %0d", o_perf_wait_cnt, exp_wait); end
    endtask

    task automatic test_stall_buffer();
        apply_reset();
        i_imem_gnt = 1'b1;
        next_cycle();
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = 32'h1234_5678;
        i_stall_d     = 1'b1;
        #1;
        compared++; if (o_pc_en !== 1'b0 || o_ifid_en !== 1'b0 || o_imem_req !== 1'b0) begin mismatched++; $display("FAIL stall_return: got pc_en=%0b ifid=%0b req=%0b want 0/0/0", o_pc_en, o_ifid_en, o_imem_req); end
        next_cycle();
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'hDEAD_BEEF;
        #1;
        compared++; if (o_pc_en !== 1'b0 || o_imem_req !== 1'b0 || o_instr_f !== '0) begin mismatched++; $display("FAIL stall_hold: got pc_en=%0b req=%0b instr=%0h want 0/0/0", o_pc_en, o_imem_req, o_instr_f); end
        next_cycle();
        i_stall_d = 1'b0;
        #1;
        compared++; if (o_instr_f !== 32'h1234_5678 || o_pc_instr_f !== 32'h0 || o_pc_en !== 1'b1 || o_imem_req !== 1'b0) begin mismatched++; $display("FAIL stall_drain: got %0h@%0h pc_en=%0b req=%0b want 12345678@0 1 0", o_instr_f, o_pc_instr_f, o_pc_en, o_imem_req); end
        next_cycle();
        #1;
        compared++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h4) begin mismatched++; $display("FAIL stall_next_req: got req=%0b addr=%0h want 1/4", o_imem_req, o_imem_addr); end
    endtask

    task automatic test_redirect_wait();
        logic [PW-1:0] exp_kill;
        apply_reset();
        i_imem_gnt = 1'b1;
        next_cycle();
        i_imem_gnt = 1'b0;
        i_pc_src_e = 1'b1;
        target     = 32'h100;
        #1;
        compared++; if (o_pc_en !== 1'b1 || o_flush_d !== 1'b1 || o_imem_req !== 1'b0) begin mismatched++; $display("FAIL rw_redirect: got pc_en=%0b flush=%0b req=%0b want 1/1/0", o_pc_en, o_flush_d, o_imem_req); end
        next_cycle();
        i_pc_src_e    = 1'b0;
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = 32'hBAD0_0BAD;
        #1;
        compared++; if (o_pc_en !== 1'b0 || o_instr_f !== '0 || o_flush_d !== 1'b1 || o_dbg_state !== 2'd2) begin mismatched++; $display("FAIL rw_stale: got pc_en=%0b instr=%0h flush=%0b st=%0d want 0/0/1/2", o_pc_en, o_instr_f, o_flush_d, o_dbg_state); end
        next_cycle();
        drive_quiet();
        #1;
        compared++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h100) begin mismatched++; $display("FAIL rw_next_req: got req=%0b addr=%0h want 1/100", o_imem_req, o_imem_addr); end
`ifdef RISCV_FETCH_CTRL_PERF_EN
        exp_kill = 1;
`else
        exp_kill = 0;
`endif
        compared++; if (o_perf_kill_cnt !== exp_kill) begin mismatched++; $display("FAIL rw_kill_cnt: got %0d want %0d", o_perf_kill_cnt, exp_kill); end
    endtask

    task automatic test_redirect_rvalid();
        logic [PW-1:0] exp_kill;
        apply_reset();
        i_imem_gnt = 1'b1;
        next_cycle();
        i_imem_gnt    = 1'b0;
        i_pc_src_e    = 1'b1;
        target        = 32'h100;
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = 32'h0000_0013;
        #1;
        compared++; if (o_pc_en !== 1'b1 || o_flush_d !== 1'b1 || o_instr_f !== '0) begin mismatched++; $display("FAIL rr_drop: got pc_en=%0b flush=%0b instr=%0h want 1/1/0", o_pc_en, o_flush_d, o_instr_f); end
        next_cycle();
        drive_quiet();
        #1;
        compared++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h100) begin mismatched++; $display("FAIL rr_next_req: got req=%0b addr=%0h want 1/100", o_imem_req, o_imem_addr); end
`ifdef RISCV_FETCH_CTRL_PERF_EN
        exp_kill = 1;
`else
        exp_kill = 0;
`endif
        compared++; if (o_perf_kill_cnt !== exp_kill) begin mismatched++; $display("FAIL rr_kill_cnt: got %0d want %0d", o_perf_kill_cnt, exp_kill); end
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        i_imem_gnt = 1'b1;
        next_cycle();
        i_imem_gnt = 1'b0;
        i_rstn     = 1'b0;
        #1;
        compared++; if ({o_imem_req, o_pc_en, o_ifid_en, o_flush_d} !== 4'b0 || o_instr_f !== '0 || o_imem_addr !== '0) begin mismatched++; $display("FAIL rmid_outputs: got req=%0b pc_en=%0b ifid=%0b flush=%0b want all 0", o_imem_req, o_pc_en, o_ifid_en, o_flush_d); end
        next_cycle();
        i_rstn = 1'b1;
        #1;
        compared++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0 || o_dbg_state !== 2'd0) begin mismatched++; $display("FAIL rmid_restart: got req=%0b addr=%0h st=%0d want 1/0/0", o_imem_req, o_imem_addr, o_dbg_state); end
        compared++; if (o_pc_en !== 1'b0 || o_flush_d !== 1'b1) begin mismatched++; $display("FAIL rmid_empty_buf: got pc_en=%0b flush=%0b want 0/1", o_pc_en, o_flush_d); end
        next_cycle();
    endtask

    // Random run: a memory model with random grant and latency, random stalls and
    // redirects; deliveries must follow program order, restarting at each target.
    task automatic test_random();
        logic [XLEN-1:0] exp_pc;
        logic [XLEN-1:0] addr_out;
        logic            outstanding, killed, rv, redir, deliv;
        int              lat, ndeliv;
        logic [PW-1:0]   exp_wait, exp_kill;

        apply_reset();
        exp_pc = '0; outstanding = 0; killed = 0; lat = 0; ndeliv = 0;
        exp_wait = '0; exp_kill = '0; addr_out = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            drive_quiet();
            rv    = outstanding && (lat == 1);
            redir = ($urandom_range(0, 11) == 0);
            if (outstanding) begin
                exp_wait++;
                if (redir && !killed) begin exp_kill++; killed = 1; end
                lat--;
                if (lat == 0) outstanding = 0;
            end
            i_stall_d     = ($urandom_range(0, 3) == 0);
            i_pc_src_e    = redir;
            target        = 32'($urandom_range(0, 1023)) << 2;
            i_imem_rvalid = rv;
            i_imem_rdata  = rv ? instr_of(addr_out) : 32'($urandom);
            #1;
            if (o_imem_req && ($urandom_range(0, 2) != 0)) begin
                i_imem_gnt = 1'b1;
                compared++; if (o_imem_addr !== exp_pc) begin mismatched++; $display("FAIL rnd_req_addr cyc%0d: got %0h want %0h", cyc, o_imem_addr, exp_pc); end
                addr_out    = o_imem_addr;
                outstanding = 1;
                killed      = 0;
                lat         = $urandom_range(1, 4);
            end
            #1;
            deliv = o_pc_en && !redir;
            compared++; if (o_ifid_en !== !i_stall_d) begin mismatched++; $display("FAIL rnd_ifid cyc%0d: got %0b want %0b", cyc, o_ifid_en, !i_stall_d); end
            if (redir) begin
                compared++; if (o_pc_en !== 1'b1 || o_flush_d !== 1'b1 || o_imem_req !== 1'b0 || o_instr_f !== '0) begin mismatched++; $display("FAIL rnd_redirect cyc%0d: got pc_en=%0b flush=%0b req=%0b instr=%0h want 1/1/0/0", cyc, o_pc_en, o_flush_d, o_imem_req, o_instr_f); end
                exp_pc = target;
            end else if (deliv) begin
                exp_q.push_back(exp_pc);
                compared++; if (i_stall_d !== 1'b0 || o_flush_d !== 1'b0) begin mismatched++; $display("FAIL rnd_deliver_ctrl cyc%0d: got stall=%0b flush=%0b want 0/0", cyc, i_stall_d, o_flush_d); end
                compared++; if (o_pc_instr_f !== exp_q[0] || o_instr_f !== instr_of(exp_q[0])) begin mismatched++; $display("FAIL rnd_deliver cyc%0d: got %0h@%0h want %0h@%0h", cyc, o_instr_f, o_pc_instr_f, instr_of(exp_q[0]), exp_q[0]); end
                void'(exp_q.pop_front());
                exp_pc = exp_pc + 32'd4;
                ndeliv++;
            end else begin
                compared++; if (o_instr_f !== '0 || o_pc_instr_f !== '0 || o_flush_d !== !i_stall_d) begin mismatched++; $display("FAIL rnd_idle cyc%0d: got instr=%0h pc=%0h flush=%0b want 0/0/%0b", cyc, o_instr_f, o_pc_instr_f, o_flush_d, !i_stall_d); end
            end
            next_cycle();
        end
        drive_quiet();
        #1;
        compared++; if (ndeliv < 40) begin mismatched++; $display("FAIL rnd_throughput: got %0d deliveries want >= 40", ndeliv); end
`ifndef RISCV_FETCH_CTRL_PERF_EN
        exp_wait = '0;
        exp_kill = '0;
`endif
        compared++; if (o_perf_wait_cnt !== exp_wait) begin mismatched++; $display("FAIL rnd_wait_cnt: got %0d want %0d", o_perf_wait_cnt, exp_wait); end
        compared++; if (o_perf_kill_cnt !== exp_kill) begin mismatched++; $display("FAIL rnd_kill_cnt: got %0d want %0d", o_perf_kill_cnt, exp_kill); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        i_rstn = 1'b0;
        drive_quiet();
        target = '0;
        test_reset();
        test_single_cycle();
        test_slow_mem();
        test_stall_buffer();
        test_redirect_wait();
        test_redirect_rvalid();
        test_reset_mid_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
